// File: rtl/tw_addr_gen_mdc_if.sv
// Handshake and address bus between a twiddle address sequencer and its driver.
// The master drives requests and operands; the slave returns the address stream and status.
interface tw_addr_gen_mdc_if #(
   parameter int LOGN = 12
);
   logic            start;
   logic            intt;
   logic            in_valid;
   logic            busy;
   logic [LOGN-1:0] raddr;
   logic            intt_o;
   logic            addr_valid;
   logic            tw_valid;
   logic            done;

   modport master (
      output start, intt, in_valid,
      input  busy, raddr, intt_o, addr_valid, tw_valid, done
   );

   modport slave (
      input  start, intt, in_valid,
      output busy, raddr, intt_o, addr_valid, tw_valid, done
   );
endinterface

// File: rtl/tw_addr_gen_mdc.sv
// Per-stage twiddle ROM read-address sequencer for the MDC NWC NTT/INTT pipeline.
// One address per accepted butterfly; tw_valid/done are delayed to line up with ROM wrapper dout.
module tw_addr_gen_mdc #(
   parameter int LOGN       = 12,
   parameter int STAGE      = 0,
   parameter int DELAY_BROM = 2
)(
   input  logic              clk,
   input  logic              rst_n,
   tw_addr_gen_mdc_if.slave  io_bus
);
   localparam int SH_NTT  = LOGN - 1 - STAGE;
   localparam int SH_INTT = STAGE;
   localparam logic [LOGN-2:0] CNT_LAST = '1;

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_RUN   = 2'd1;
   localparam logic [1:0] S_DRAIN = 2'd2;

   logic [1:0]          r_state;
   logic [LOGN-2:0]     r_cnt;
   logic [LOGN-1:0]     r_raddr;
   logic                r_intt_o;
   logic                r_addr_valid;
   logic                r_last;
   logic [DELAY_BROM:0] r_vpipe;
   logic [DELAY_BROM:0] r_lpipe;

   logic                w_accept;
   logic                w_cnt_last;
   logic                w_done;
   logic [LOGN-2:0]     w_cnt_sh;

   assign w_accept   = (r_state == S_RUN) && io_bus.in_valid;
   assign w_cnt_last = (r_cnt == CNT_LAST);
   // CT walks groups from coarse to fine; GS mirrors the stage order.
   assign w_cnt_sh   = r_intt_o ? (r_cnt >> SH_INTT) : (r_cnt >> SH_NTT);
   assign w_done     = r_vpipe[DELAY_BROM] & r_lpipe[DELAY_BROM];

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state      <= S_IDLE;
         r_cnt        <= '0;
         r_raddr      <= '0;
         r_intt_o     <= 1'b0;
         r_addr_valid <= 1'b0;
         r_last       <= 1'b0;
         r_vpipe      <= '0;
         r_lpipe      <= '0;
      end else begin
         r_addr_valid <= w_accept;
         r_last       <= w_accept & w_cnt_last;
         if (w_accept) begin
            r_raddr <= {1'b0, w_cnt_sh};
         end

         // DELAY_BROM ROM cycles plus the wrapper's output register.
         r_vpipe[0] <= r_addr_valid;
         r_lpipe[0] <= r_addr_valid & r_last;
         for (int i = 1; i <= DELAY_BROM; i++) begin
            r_vpipe[i] <= r_vpipe[i-1];
            r_lpipe[i] <= r_lpipe[i-1];
         end

         case (r_state)
            S_IDLE: begin
               if (io_bus.start) begin
                  r_intt_o <= io_bus.intt;
                  r_cnt    <= '0;
                  r_state  <= S_RUN;
               end
            end
            S_RUN: begin
               if (w_accept) begin
                  if (w_cnt_last) begin
                     r_state <= S_DRAIN;
                  end else begin
                     r_cnt <= r_cnt + 1'b1;
                  end
               end
            end
            S_DRAIN: begin
               if (w_done) begin
                  r_state <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign io_bus.busy       = (r_state != S_IDLE);
   assign io_bus.raddr      = r_raddr;
   assign io_bus.intt_o     = r_intt_o;
   assign io_bus.addr_valid = r_addr_valid;
   assign io_bus.tw_valid   = r_vpipe[DELAY_BROM];
   assign io_bus.done       = w_done;
endmodule
